// File: rtl/stage_sequencer.sv
// Stage controller for the multi-cycle CPU: steps an N-stage instruction cycle from an
// internal divider (auto) or a debounced button (manual), with memory stalls, breakpoint and halt.
module stage_sequencer #(
  parameter int                    NUM_STAGES      = 5,
  parameter int                    STAGE_W         = 3,
  parameter logic [NUM_STAGES-1:0] MEM_STAGE_MASK  = 5'b01001,
  parameter int                    AUTO_DIV        = 8,
  parameter int                    DEBOUNCE_CYCLES = 4,
  parameter int                    ADDR_W          = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               isAuto,
  input  logic               nextStage,
  input  logic               memReady,
  input  logic               halt,
  input  logic               bpEnable,
  input  logic [ADDR_W-1:0]  bpAddr,
  input  logic [ADDR_W-1:0]  pc,
  output logic [STAGE_W-1:0] stage,
  output logic               stageStart,
  output logic               memReq,
  output logic               instrDone,
  output logic               paused,
  output logic               halted,
  output logic [15:0]        instrCount
);

  localparam int                 DIV_W      = $clog2(AUTO_DIV);
  localparam int                 DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int                 PAD_N      = 1 << STAGE_W;
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(AUTO_DIV - 1);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  // Mask padded to the full stage-index range so any stage value indexes it safely.
  localparam logic [PAD_N-1:0]   MEM_MASK   = PAD_N'(MEM_STAGE_MASK);

  logic [1:0]         btn_sync;
  logic               btn_level;
  logic [DB_W-1:0]    db_cnt;
  logic               man_tok;
  logic [DIV_W-1:0]   div;
  logic               is_auto_q;
  logic               mem_done;

  logic               auto_tok;
  logic               token;
  logic               resume;
  logic               mem_ok;
  logic               advance;
  logic               at_last;
  logic [STAGE_W-1:0] next_stage;

  // Button path: 2-flop synchroniser, then a level that flips only after the
  // synchronised value has disagreed with it for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      btn_sync  <= '0;
      btn_level <= 1'b0;
      db_cnt    <= '0;
      man_tok   <= 1'b0;
    end else begin
      btn_sync <= {btn_sync[0], nextStage};
      man_tok  <= 1'b0;
      if (btn_sync[1] == btn_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_level <= btn_sync[1];
        db_cnt    <= '0;
        man_tok   <= btn_sync[1];
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  always_comb begin
    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    auto_tok   = isAuto && !paused && !halted && (div == DIV_LAST);
    token      = isAuto ? auto_tok : man_tok;
    resume     = paused && man_tok;
    mem_ok     = !MEM_MASK[stage] || mem_done || (memReq && memReady);
    advance    = token && !halted && !paused && mem_ok;
    at_last    = (stage == LAST_STAGE);
    next_stage = at_last ? '0 : stage + STAGE_W'(1);
  end

  // is_auto_q resets high so a reset taken in auto mode does not look like a 0->1 switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage      <= '0;
      stageStart <= 1'b1;
      memReq     <= MEM_MASK[0];
      instrDone  <= 1'b0;
      paused     <= 1'b0;
      halted     <= 1'b0;
      instrCount <= '0;
      div        <= '0;
      is_auto_q  <= 1'b1;
      mem_done   <= 1'b0;
    end else begin
      is_auto_q  <= isAuto;
      stageStart <= 1'b0;
      instrDone  <= 1'b0;

      if (advance || (isAuto && !is_auto_q)) begin
        div <= '0;
      end else if (isAuto && !paused && !halted) begin
        div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
      end

      if (resume) begin
        paused <= 1'b0;
      end

      if (advance) begin
        stage    <= next_stage;
        mem_done <= 1'b0;
        if (at_last && halt) begin
          halted <= 1'b1;
          memReq <= 1'b0;
        end else begin
          stageStart <= 1'b1;
          memReq     <= MEM_MASK[next_stage];
        end
        if (at_last) begin
          instrDone  <= 1'b1;
          instrCount <= instrCount + 16'd1;
          if (!halt && isAuto && bpEnable && (pc == bpAddr)) begin
            paused <= 1'b1;
          end
        end
      end else if (memReq && memReady) begin
        memReq   <= 1'b0;
        mem_done <= 1'b1;
      end
    end
  end

endmodule
